// File: rtl/sensor_seq_gen_pkg.sv
// Shared types and constants for the door-sensor sequence generator.
package sensor_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        GAP1,
        SECOND,
        TAIL
    } seq_state_t;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;
    localparam int   SENS_A    = 0;
    localparam int   SENS_B    = 1;
    localparam int   BTN_W     = 4;

    function automatic logic [BTN_W-1:0] sensor_bit(input int idx);
        logic [BTN_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sensor_seq_gen_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sensor_seq_gen.sv
// Turns entry/exit requests into timed two-sensor pulse sequences on a btn-style bus.
// Optional per-direction completion counters are enabled by SENSOR_SEQ_STATS_EN.
module sensor_seq_gen
    import sensor_seq_pkg::*;
#(
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_dir,
    output logic             req_ready,
    output logic [BTN_W-1:0] btn_out,
    output logic             busy,
    output logic             done
`ifdef SENSOR_SEQ_STATS_EN
    ,
    output logic [15:0]      entry_count,
    output logic [15:0]      exit_count
`endif
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             dir_q;
    logic             dir_next;
    logic             load;
    logic             dec;
    logic [CNT_W-1:0] load_val;
    logic             zero;
    logic             finish;
    logic [BTN_W-1:0] btn_next;

    seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .dec     (dec),
        .load_val(load_val),
        .zero    (zero)
    );

    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        load       = 1'b0;
        dec        = 1'b0;
        load_val   = '0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_next = FIRST;
                    dir_next   = req_dir;
                    load       = 1'b1;
                    load_val   = PULSE_LOAD;
                end
            end
            FIRST: begin
                if (zero) begin
                    state_next = GAP1;
                    load       = 1'b1;
                    load_val   = GAP_LOAD;
                end else begin
                    dec = 1'b1;
                end
            end
            GAP1: begin
                if (zero) begin
                    state_next = SECOND;
                    load       = 1'b1;
                    load_val   = PULSE_LOAD;
                end else begin
                    dec = 1'b1;
                end
            end
            SECOND: begin
                if (zero) begin
                    state_next = TAIL;
                    load       = 1'b1;
                    load_val   = GAP_LOAD;
                end else begin
                    dec = 1'b1;
                end
            end
            TAIL: begin
                if (zero) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered bus lines up with the state.
        btn_next = '0;
        if (state_next == FIRST) begin
            btn_next = sensor_bit((dir_next == DIR_EXIT) ? SENS_B : SENS_A);
        end else if (state_next == SECOND) begin
            btn_next = sensor_bit((dir_next == DIR_EXIT) ? SENS_A : SENS_B);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir_q     <= DIR_ENTRY;
            btn_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_next;
            dir_q     <= dir_next;
            btn_out   <= btn_next;
            busy      <= (state_next != IDLE);
            done      <= finish;
            req_ready <= (state_next == IDLE);
        end
    end

`ifdef SENSOR_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_count <= '0;
            exit_count  <= '0;
        end else if (finish) begin
            if (dir_q == DIR_ENTRY) begin
                entry_count <= entry_count + 16'd1;
            end else begin
                exit_count <= exit_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sensor_seq_gen.sv
// Randomized bench for sensor_seq_gen: two lanes (default timing and PULSE=3/GAP=2),
// each compared every cycle against a queue-of-expected-bus-values reference model.
module tb_sensor_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int P = (g == 0) ? 1 : 3;
        localparam int G = (g == 0) ? 1 : 2;

        logic       rst;
        logic       valid;
        logic       dir;
        logic       ready;
        logic [3:0] btn;
        logic       busy;
        logic       done;
        logic       fin = 1'b0;
`ifdef SENSOR_SEQ_STATS_EN
        logic [15:0] n_entry;
        logic [15:0] n_exit;
        logic [15:0] m_entry = '0;
        logic [15:0] m_exit  = '0;
`endif

        sensor_seq_gen #(
            .PULSE_CYCLES(P),
            .GAP_CYCLES  (G),
            .CNT_W       (8)
        ) dut (
            .clk        (clk),
            .reset      (rst),
            .req_valid  (valid),
            .req_dir    (dir),
            .req_ready  (ready),
            .btn_out    (btn),
            .busy       (busy),
            .done       (done)
`ifdef SENSOR_SEQ_STATS_EN
            ,
            .entry_count(n_entry),
            .exit_count (n_exit)
`endif
        );

        // Reference model: each accepted request expands into its full list of bus values.
        logic [3:0] q[$];
        logic       done_e  = 1'b0;
        logic       started = 1'b0;
        logic       in_rst  = 1'b0;
        logic       cur_dir = 1'b0;

        always @(posedge clk) begin
            in_rst = rst;
            if (rst) begin
                q.delete();
                done_e  = 1'b0;
                started = 1'b1;
`ifdef SENSOR_SEQ_STATS_EN
                m_entry = '0;
                m_exit  = '0;
`endif
            end else if (started) begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                    done_e = (q.size() == 0);
`ifdef SENSOR_SEQ_STATS_EN
                    if (done_e) begin
                        if (cur_dir) m_exit = m_exit + 16'd1;
                        else         m_entry = m_entry + 16'd1;
                    end
`endif
                end else begin
                    done_e = 1'b0;
                    if (valid) begin
                        cur_dir = dir;
                        for (int i = 0; i < P; i++) q.push_back(dir ? 4'b0010 : 4'b0001);
                        for (int i = 0; i < G; i++) q.push_back(4'b0000);
                        for (int i = 0; i < P; i++) q.push_back(dir ? 4'b0001 : 4'b0010);
                        for (int i = 0; i < G; i++) q.push_back(4'b0000);
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (started) begin
                check_eq($sformatf("L%0d btn", g), btn, (q.size() > 0) ? q[0] : 4'b0000);
                check_eq($sformatf("L%0d busy", g), busy, q.size() > 0);
                check_eq($sformatf("L%0d done", g), done, done_e);
                check_eq($sformatf("L%0d both_high", g), btn[1] & btn[0], 1'b0);
                if (!in_rst) check_eq($sformatf("L%0d ready", g), ready, q.size() == 0);
`ifdef SENSOR_SEQ_STATS_EN
                check_eq($sformatf("L%0d entry_count", g), n_entry, m_entry);
                check_eq($sformatf("L%0d exit_count", g), n_exit, m_exit);
`endif
            end
        end

        initial begin
            int  k;
            int  n;
            int  acc_n;
            logic acc;
            rst   = 1'b1;
            valid = 1'b0;
            dir   = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check_eq($sformatf("L%0d rst_btn", g), btn, 4'b0000);
            check_eq($sformatf("L%0d rst_ready", g), ready, 1'b1);
            check_eq($sformatf("L%0d rst_busy", g), busy, 1'b0);
            check_eq($sformatf("L%0d rst_done", g), done, 1'b0);

            // Single entry then single exit, measuring the busy window.
            for (int d = 0; d < 2; d++) begin
                valid = 1'b1;
                dir   = d[0];
                @(negedge clk);
                valid = 1'b0;
                n = 0;
                k = 0;
                while (!done && k < 200) begin
                    if (busy) n++;
                    k++;
                    @(negedge clk);
                end
                check_eq($sformatf("L%0d single_done", g), done, 1'b1);
                check_eq($sformatf("L%0d busy_len", g), n, 2 * P + 2 * G);
            end

            // Back-to-back with alternating direction; each later accept lands on a done cycle.
            valid = 1'b1;
            dir   = 1'b0;
            acc_n = 0;
            k     = 0;
            while (acc_n < 6 && k < 400) begin
                if (ready) begin
                    if (acc_n > 0) check_eq($sformatf("L%0d b2b_done", g), done, 1'b1);
                    acc_n++;
                    @(negedge clk);
                    dir = ~dir;
                end else begin
                    @(negedge clk);
                end
                k++;
            end
            valid = 1'b0;
            check_eq($sformatf("L%0d b2b_count", g), acc_n, 6);

            // Random requests with occasional resets; pending requests keep their direction.
            for (int c = 0; c < 600; c++) begin
                if (!valid) begin
                    valid = ($urandom_range(0, 2) == 0);
                    dir   = $urandom_range(0, 1);
                end
                rst = ($urandom_range(0, 63) == 0);
                acc = valid && ready && !rst;
                @(negedge clk);
                if (acc) valid = 1'b0;
            end
            rst   = 1'b0;
            valid = 1'b0;
            k = 0;
            while (!ready && k < 200) begin
                k++;
                @(negedge clk);
            end
            check_eq($sformatf("L%0d drain_idle", g), ready, 1'b1);

            // Reset while the second pulse is on the bus.
            valid = 1'b1;
            dir   = 1'b0;
            @(negedge clk);
            valid = 1'b0;
            k = 0;
            while (btn != 4'b0010 && k < 200) begin
                k++;
                @(negedge clk);
            end
            check_eq($sformatf("L%0d reach_second", g), btn, 4'b0010);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_eq($sformatf("L%0d mid_rst_btn", g), btn, 4'b0000);
            check_eq($sformatf("L%0d mid_rst_busy", g), busy, 1'b0);
            check_eq($sformatf("L%0d mid_rst_done", g), done, 1'b0);
            valid = 1'b1;
            dir   = 1'b0;
            @(negedge clk);
            valid = 1'b0;
            check_eq($sformatf("L%0d fresh_first", g), btn, 4'b0001);
            k = 0;
            while (!done && k < 200) begin
                k++;
                @(negedge clk);
            end
            check_eq($sformatf("L%0d fresh_done", g), done, 1'b1);
            @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(lane[0].fin && lane[1].fin) && k < 20000) begin
            k++;
            @(negedge clk);
        end
        check_eq("lanes_finished", {lane[1].fin, lane[0].fin}, 2'b11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
